// File: rtl/triangular_call_issuer.sv
// Job FIFO + call issuer for the triangular HLS component: issues queued jobs on start/busy,
// collects done/stall returns into tagged in-order completions, and runs a drain/flush sequence.
// Optional macro TRIANGULAR_SKIP_ZERO_N_EN: n==0 jobs are retired locally instead of being issued.
module triangular_call_issuer #(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int TAG_W           = 8
) (
  input  logic                                 clock,
  input  logic                                 resetn,
  input  logic                                 job_valid,
  output logic                                 job_ready,
  input  logic [63:0]                          job_x,
  input  logic [63:0]                          job_A,
  input  logic [31:0]                          job_n,
  input  logic                                 flush,
  output logic                                 flush_done,
  output logic                                 start,
  input  logic                                 busy,
  output logic [63:0]                          x,
  output logic [63:0]                          A,
  output logic [31:0]                          n,
  input  logic                                 done,
  output logic                                 stall,
  output logic                                 cmpl_valid,
  input  logic                                 cmpl_ready,
  output logic [TAG_W-1:0]                     cmpl_tag,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] inflight
);
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;
  localparam int INF_W = $clog2(MAX_OUTSTANDING+1);

  typedef struct packed {
    logic [63:0] x;
    logic [63:0] a;
    logic [31:0] n;
  } job_t;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_FLUSH, S_IDLE} state_t;

  state_t            r_state, w_state_nxt;
  job_t              r_mem [DEPTH];
  logic [PW-1:0]     r_wptr, r_rptr;
  logic [INF_W-1:0]  r_inflight;
  logic [TAG_W-1:0]  r_issue_tag, r_retire_tag, r_cmpl_tag;
  logic              r_cmpl_valid, r_rdy;

  logic w_empty, w_full, w_run, w_push, w_pop, w_ret, w_skip, w_head_ok;
  job_t w_head;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_run   = (r_state == S_RUN);
  assign w_head  = r_mem[r_rptr[AW-1:0]];

`ifdef TRIANGULAR_SKIP_ZERO_N_EN
  // Zero-length jobs bypass the component once nothing is ahead of them, keeping tags in order.
  assign w_head_ok = (w_head.n != 32'd0);
  assign w_skip    = w_run && !w_empty && !w_head_ok && (r_inflight == '0) && !stall;
`else
  assign w_head_ok = 1'b1;
  assign w_skip    = 1'b0;
`endif

  assign job_ready  = r_rdy && !w_full && w_run;
  assign start      = !w_empty && w_run && (r_inflight < INF_W'(MAX_OUTSTANDING)) && w_head_ok;
  assign x          = w_head.x;
  assign A          = w_head.a;
  assign n          = w_head.n;
  assign stall      = r_cmpl_valid && !cmpl_ready;
  assign cmpl_valid = r_cmpl_valid;
  assign cmpl_tag   = r_cmpl_tag;
  assign inflight   = r_inflight;
  assign flush_done = (r_state == S_FLUSH);

  assign w_push = job_valid && job_ready;
  assign w_pop  = start && !busy;
  // A return with nothing outstanding is a protocol error and is dropped.
  assign w_ret  = done && !stall && (r_inflight != '0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:   if (flush) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_inflight == '0 && !r_cmpl_valid) w_state_nxt = S_FLUSH;
      S_FLUSH: w_state_nxt = S_IDLE;
      S_IDLE:  if (!flush) w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_RUN;
      r_rdy   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rdy   <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (r_state == S_FLUSH) begin
      r_rptr <= r_wptr;
    end else begin
      if (w_push) begin
        r_mem[r_wptr[AW-1:0]] <= '{x: job_x, a: job_A, n: job_n};
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop || w_skip) r_rptr <= r_rptr + PW'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_inflight   <= '0;
      r_issue_tag  <= '0;
      r_retire_tag <= '0;
      r_cmpl_valid <= 1'b0;
      r_cmpl_tag   <= '0;
    end else begin
      case ({w_pop, w_ret})
        2'b10:   r_inflight <= r_inflight + INF_W'(1);
        2'b01:   r_inflight <= r_inflight - INF_W'(1);
        default: r_inflight <= r_inflight;
      endcase
      if (w_pop || w_skip) r_issue_tag <= r_issue_tag + TAG_W'(1);
      if (w_ret || w_skip) begin
        r_cmpl_valid <= 1'b1;
        r_cmpl_tag   <= r_retire_tag;
        r_retire_tag <= r_retire_tag + TAG_W'(1);
      end else if (cmpl_ready) begin
        r_cmpl_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_triangular_call_issuer.sv
// Randomized bench for triangular_call_issuer against a queue-based transaction model.
module tb_triangular_call_issuer;
  localparam int DEPTH = 4;
  localparam int MAXO  = 8;
  localparam int TAG_W = 8;

  logic        clock = 1'b0;
  logic        resetn;
  logic        job_valid, job_ready, flush, flush_done, start, busy, done, stall;
  logic        cmpl_valid, cmpl_ready;
  logic [63:0] job_x, job_A, x, A;
  logic [31:0] job_n, n;
  logic [TAG_W-1:0] cmpl_tag;
  logic [3:0]  inflight;

  always #5 clock = ~clock;

  triangular_call_issuer #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .TAG_W(TAG_W)) dut (
    .clock(clock), .resetn(resetn), .job_valid(job_valid), .job_ready(job_ready),
    .job_x(job_x), .job_A(job_A), .job_n(job_n), .flush(flush), .flush_done(flush_done),
    .start(start), .busy(busy), .x(x), .A(A), .n(n), .done(done), .stall(stall),
    .cmpl_valid(cmpl_valid), .cmpl_ready(cmpl_ready), .cmpl_tag(cmpl_tag), .inflight(inflight)
  );

  typedef struct packed { logic [63:0] x; logic [63:0] a; logic [31:0] n; } job_t;

  // Model: queued jobs, tags of issued calls awaiting return, completion register, flush phase.
  job_t q[$];
  int   iss[$];
  bit   cv, rdy;
  int   ctag, itag, st, npush;
  bit   e_ready, e_start, e_stall;
  int   ntests = 0, nfail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete(); iss.delete();
    cv = 0; rdy = 0; ctag = 0; itag = 0; st = 0;
  endtask

  task automatic model_check();
    e_ready = rdy && q.size() < DEPTH && st == 0;
    e_start = q.size() > 0 && iss.size() < MAXO && st == 0;
`ifdef TRIANGULAR_SKIP_ZERO_N_EN
    if (q.size() > 0 && q[0].n == 0) e_start = 0;
`endif
    e_stall = cv && !cmpl_ready;
    chk("job_ready", job_ready, e_ready);
    chk("start", start, e_start);
    if (e_start && start) begin
      chk("x", x, q[0].x);
      chk("A", A, q[0].a);
      chk("n", n, q[0].n);
    end
    chk("stall", stall, e_stall);
    chk("cmpl_valid", cmpl_valid, cv);
    if (cv) chk("cmpl_tag", cmpl_tag, ctag);
    chk("inflight", inflight, iss.size());
    chk("flush_done", flush_done, st == 2);
  endtask

  task automatic model_update();
    bit push, pop, ret, skp;
    int st0, nin0;
    bit cv0;
    st0 = st; nin0 = iss.size(); cv0 = cv;
    push = job_valid && e_ready;
    pop  = e_start && !busy;
    ret  = done && !e_stall && nin0 > 0;
    skp  = 0;
`ifdef TRIANGULAR_SKIP_ZERO_N_EN
    skp = st0 == 0 && q.size() > 0 && q[0].n == 0 && nin0 == 0 && !e_stall;
`endif
    if (ret) begin cv = 1; ctag = iss.pop_front(); end
    else if (skp) begin cv = 1; ctag = itag; itag = (itag + 1) % (1 << TAG_W); end
    else if (cmpl_ready) cv = 0;
    if (pop) begin
      iss.push_back(itag);
      itag = (itag + 1) % (1 << TAG_W);
      void'(q.pop_front());
    end
    if (skp) void'(q.pop_front());
    if (push) begin q.push_back('{x: job_x, a: job_A, n: job_n}); npush++; end
    case (st0)
      0: if (flush) st = 1;
      1: if (nin0 == 0 && !cv0) st = 2;
      2: begin q.delete(); st = 3; end
      default: if (!flush) st = 0;
    endcase
    rdy = 1;
  endtask

  // Called at a negedge with inputs already set; returns at the next negedge.
  task automatic step();
    #1 model_check();
    @(posedge clock);
    model_update();
    @(negedge clock);
  endtask

  task automatic idle_in();
    job_valid = 0; busy = 0; done = 0; flush = 0; cmpl_ready = 1;
    job_x = '0; job_A = '0; job_n = '0;
  endtask

  int fcnt;

  initial begin
    resetn = 0;
    idle_in();
    model_reset();
    npush = 0;
    repeat (3) @(negedge clock);
    chk("rst job_ready", job_ready, 0);
    chk("rst start", start, 0);
    chk("rst stall", stall, 0);
    chk("rst cmpl_valid", cmpl_valid, 0);
    chk("rst cmpl_tag", cmpl_tag, 0);
    chk("rst inflight", inflight, 0);
    chk("rst flush_done", flush_done, 0);
    chk("rst x", x, 0);
    resetn = 1;
    step();

    // Single job: visible on start the next cycle, returns as tag 0.
    job_valid = 1; job_x = 64'h1000; job_A = 64'h2000; job_n = 32'd5;
    step();
    idle_in();
    chk("single start", start, 1);
    chk("single x", x, 64'h1000);
    chk("single A", A, 64'h2000);
    chk("single n", n, 32'd5);
    step();
    chk("single inflight", inflight, 1);
    done = 1;
    step();
    done = 0;
    chk("single cmpl_valid", cmpl_valid, 1);
    chk("single cmpl_tag", cmpl_tag, 0);
    chk("single inflight0", inflight, 0);
    step();

    // Outstanding limit: 9 jobs, no returns -> 8 issued, start held low.
    npush = 0;
    for (int i = 0; i < 40; i++) begin
      job_valid = (npush < 9);
      job_x = 64'(i); job_A = 64'(i + 100); job_n = 32'(i + 1);
      step();
    end
    idle_in();
    chk("max inflight", inflight, 8);
    chk("max start", start, 0);
    done = 1;
    step();
    done = 0;
    step();
    chk("max refill inflight", inflight, 8);
    done = 1;
    repeat (12) step();
    done = 0;
    chk("max drained", inflight, 0);
    step();

    // Flush: 2 issued, 3 queued behind a busy component.
    npush = 0;
    for (int i = 0; i < 20 && npush < 5; i++) begin
      job_valid = 1; busy = (npush >= 2);
      job_x = 64'(i + 7); job_A = 64'(i + 9); job_n = 32'(i + 3);
      step();
    end
    job_valid = 0; busy = 1; flush = 1;
    step();
    chk("flush start dropped", start, 0);
    busy = 0; done = 1;
    repeat (2) step();
    done = 0;
    repeat (6) step();
    chk("flush inflight", inflight, 0);
    flush = 0;
    repeat (2) step();
    chk("flush fifo empty", start, 0);

    // Random traffic including protocol-error returns, backpressure and flushes.
    fcnt = 0;
    for (int i = 0; i < 4000; i++) begin
      job_valid  = ($urandom % 3) != 0;
      job_x      = {$urandom, $urandom};
      job_A      = {$urandom, $urandom};
      job_n      = ($urandom % 4 == 0) ? 32'd0 : $urandom;
      busy       = ($urandom % 4) == 0;
      done       = ($urandom % 3) == 0;
      cmpl_ready = ($urandom % 4) != 0;
      if (fcnt > 0) begin flush = 1; fcnt--; end
      else begin
        flush = 0;
        if ($urandom % 150 == 0) fcnt = $urandom_range(3, 20);
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
